cycle_window_profiler: RTL
==========================

Name: cycle_window_profiler

Overview:
- Consumes the free-running 32-bit cycle count from the core's cycle counter and measures code windows bounded by start/stop pulses from the CPU control path.
- Per window, it records elapsed cycles and retired instructions, tags each record with a sequence number, and queues the record in a small FIFO.
- A valid/ready port drains the FIFO for the debug/MMIO readout logic.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, >=2)
- TAG_W, 4, window sequence tag width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- count_i  in  32  current cycle count from the cycle counter
- start_i  in  1  open a window (1-cycle pulse)
- stop_i  in  1  close the current window (1-cycle pulse)
- retire_i  in  1  one instruction retired this cycle
- busy_o  out  1  window open (state RUN)
- rec_valid_o  out  1  FIFO head valid
- rec_ready_i  in  1  consumer accepts head
- rec_elapsed_o  out  32  head record: elapsed cycles
- rec_retired_o  out  32  head record: retired instructions
- rec_tag_o  out  TAG_W  head record: sequence tag
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy
- drop_cnt_o  out  8  records dropped because the FIFO was full, saturating

Behaviour:
- Reset (async) clears every output to 0, sets state to IDLE, and empties the FIFO.
  - Internal registers reset to 0: start_ts, ret_cnt, next_tag.
  - A window open at reset is discarded; no record is produced.
- State machine: IDLE, RUN.
  - IDLE, start_i: start_ts<=count_i, ret_cnt<=0, go to RUN. stop_i is ignored.
  - RUN, stop_i only: close the window, go to IDLE.
  - RUN, start_i only: restart. start_ts<=count_i, ret_cnt<=0, stay in RUN, no record, tag not consumed.
  - RUN, start_i and stop_i in the same cycle: close the current window (record pushed), then immediately open a new one (start_ts<=count_i, ret_cnt<=0), stay in RUN.
- retire_i counting:
  - In RUN, ret_cnt increments on each retire_i and saturates at 32'hFFFFFFFF.
  - A retire_i in the stop cycle is counted. A retire_i in the start cycle is not counted.
- Close computation:
  - elapsed = count_i - start_ts, modulo 2^32. A counter wrap between start and stop yields the correct difference.
  - retired = ret_cnt plus the stop-cycle retire, with the same saturation.
  - tag = next_tag; next_tag then increments and wraps at 2^TAG_W. next_tag increments only when the push succeeds.
- FIFO: registered write, show-ahead read.
  - A record pushed at cycle N is visible on rec_* with rec_valid_o=1 at N+1 when the FIFO was empty.
  - Pop occurs when rec_valid_o && rec_ready_i; the head advances next cycle.
  - rec_* hold stable while rec_valid_o=1 and rec_ready_i=0.
  - Full with a push and a pop in the same cycle: the push is accepted, level is unchanged.
  - Full with a push and no pop: the record is dropped, drop_cnt_o increments (saturates at 255), next_tag is not incremented.
  - Empty with a pop attempt: ignored, since rec_valid_o=0.
- level_o is always the exact occupancy, updated in the same cycle as the push/pop edge.
- When rec_valid_o=0, rec_* outputs are 0.

Optional Feature:
- Macro: CYCLE_WINDOW_PROFILER_MINMAX_EN.
- Defined:
  - Adds outputs min_elapsed_o[31:0] and max_elapsed_o[31:0], plus input minmax_clr_i[0:0].
  - Both are updated on every closed window, including dropped ones.
  - Reset and minmax_clr_i set min to 32'hFFFFFFFF and max to 0.
  - If a close and a clear occur in the same cycle, the clear wins.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Basic window: start at count=100, 5 retire pulses, stop at count=150 -> one record, elapsed=50, retired=5, tag=0, rec_valid_o one cycle after stop.
- Wrap: start at count=32'hFFFFFFF0, stop at count=32'h00000010 -> elapsed=32.
- Restart and back-to-back: start@10, start@20, stop@25 -> elapsed=5. Then start+stop together @40 with start@30 -> record elapsed=10, busy_o stays 1, next stop@47 -> elapsed=7.
- Overflow: DEPTH=4, rec_ready_i=0, close 6 windows -> level_o=4, drop_cnt_o=2, drained tags 0,1,2,3.
- Full with simultaneous pop: FIFO full, rec_ready_i=1 during a close -> level_o stays 4, drop_cnt_o unchanged.
- Reset mid-window: start, assert rst for 1 cycle, then stop -> no record, busy_o=0, level_o=0. With MINMAX_EN: windows of 8/3/12 -> min=3, max=12.

Source files
------------

// File: rtl/cycle_window_profiler.sv
// cycle_window_profiler: measures start/stop cycle windows, queues {elapsed, retired, tag} records in a show-ahead FIFO.
// Optional min/max elapsed tracking is enabled by defining CYCLE_WINDOW_PROFILER_MINMAX_EN.
module cycle_window_profiler #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             count_i,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic                    retire_i,
  output logic                    busy_o,
  output logic                    rec_valid_o,
  input  logic                    rec_ready_i,
  output logic [31:0]             rec_elapsed_o,
  output logic [31:0]             rec_retired_o,
  output logic [TAG_W-1:0]        rec_tag_o,
  output logic [$clog2(DEPTH):0]  level_o,
`ifdef CYCLE_WINDOW_PROFILER_MINMAX_EN
  input  logic                    minmax_clr_i,
  output logic [31:0]             min_elapsed_o,
  output logic [31:0]             max_elapsed_o,
`endif
  output logic [7:0]              drop_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, nxt;
  logic [31:0] start_ts, ret_cnt, ret_sum, elapsed;
  logic [TAG_W-1:0] next_tag;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [31:0] mem_el [DEPTH];
  logic [31:0] mem_rt [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];
  logic close, pop, push, drop;
  // window state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  // start opens or restarts a window; a lone stop closes it
  always_comb nxt = (state == IDLE) ? (start_i ? RUN : IDLE) : ((stop_i && !start_i) ? IDLE : RUN);
  // busy reflects the open window
  always_comb busy_o = (state == RUN);
  // close arithmetic and FIFO handshake; a full FIFO still accepts when the head leaves this cycle
  always_comb begin
    close = (state == RUN) && stop_i;
    ret_sum = (&ret_cnt) ? ret_cnt : ret_cnt + 32'(retire_i);
    elapsed = count_i - start_ts;
    pop = rec_valid_o && rec_ready_i;
    push = close && (level_o != FULL || pop);
    drop = close && level_o == FULL && !pop;
  end
  // window timestamp and saturating retire count; the start-cycle retire is not counted
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      start_ts <= '0;
      ret_cnt <= '0;
    end else if (start_i) begin
      start_ts <= count_i;
      ret_cnt <= '0;
    end else if (state == RUN) ret_cnt <= ret_sum;
  // FIFO pointers, occupancy, tag sequence and saturating drop count
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level_o <= '0;
      next_tag <= '0;
      drop_cnt_o <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      level_o <= level_o + (AW+1)'(push) - (AW+1)'(pop);
      next_tag <= next_tag + TAG_W'(push);
      if (drop && !(&drop_cnt_o)) drop_cnt_o <= drop_cnt_o + 8'd1;
    end
  // record storage; contents are masked by rec_valid_o so no reset is needed
  always_ff @(posedge clk)
    if (push) begin
      mem_el[wr_ptr] <= elapsed;
      mem_rt[wr_ptr] <= ret_sum;
      mem_tag[wr_ptr] <= next_tag;
    end
  // show-ahead head, forced to zero when empty
  always_comb begin
    rec_valid_o = (level_o != '0);
    rec_elapsed_o = rec_valid_o ? mem_el[rd_ptr] : '0;
    rec_retired_o = rec_valid_o ? mem_rt[rd_ptr] : '0;
    rec_tag_o = rec_valid_o ? mem_tag[rd_ptr] : '0;
  end
`ifdef CYCLE_WINDOW_PROFILER_MINMAX_EN
  // extremes over every closed window, dropped ones included; clear beats a same-cycle close
  always_ff @(posedge clk or posedge rst)
    if (rst || minmax_clr_i) begin
      min_elapsed_o <= '1;
      max_elapsed_o <= '0;
    end else if (close) begin
      if (elapsed < min_elapsed_o) min_elapsed_o <= elapsed;
      if (elapsed > max_elapsed_o) max_elapsed_o <= elapsed;
    end
`endif
endmodule
